// File: rtl/ram_16x8_loader_if.sv
// Byte-stream link between a loader source (master) and the RAM programming sequencer (slave).
// Latency: none, wiring only.
// Backpressure: a byte transfers on a rising edge where byte_valid and byte_ready are both high.
//
// Signals:
//   byte_data  - byte offered by the source
//   byte_valid - byte_data holds a byte
//   byte_ready - sequencer takes the byte on this edge
interface ram_16x8_loader_if;
    logic [7:0] byte_data;
    logic       byte_valid;
    logic       byte_ready;

    modport master (
        output byte_data,
        output byte_valid,
        input  byte_ready
    );

    modport slave (
        input  byte_data,
        input  byte_valid,
        output byte_ready
    );
endinterface

// File: rtl/ram_16x8_loader.sv
// Programs the SAP-1 16x8 RAM from a byte stream, then optionally reads it back and checks the sum.
// Latency: 1+SETUP_CYCLES+WRITE_PULSE_CYCLES+1 cycles per byte, plus 16 verify cycles when enabled.
// Backpressure: byte_ready is high only in ACCEPT; a stalled source just lengthens ACCEPT.
//
// Ports:
//   CLK, CLR             - clock, synchronous active-high reset
//   start                - begin a load (honoured only when not busy)
//   byte_if              - byte-stream slave (byte_data / byte_valid / byte_ready)
//   cpu_address/CE_bar   - CPU-side RAM controls, passed through when idle
//   ram_*                - drive the RAM_16x8 instance; ram_memory_value is its read data
//   busy, done, error    - status; done and error are sticky until the next start or CLR
//   checksum             - mod-256 sum of the 16 loaded bytes, captured at the end of a run
module ram_16x8_loader #(
    parameter int SETUP_CYCLES       = 1,
    parameter int WRITE_PULSE_CYCLES = 2,
    parameter bit VERIFY_EN          = 1'b1
) (
    input  logic                     CLK,
    input  logic                     CLR,
    input  logic                     start,
    ram_16x8_loader_if.slave         byte_if,
    input  logic [3:0]               cpu_address,
    input  logic                     cpu_CE_bar,
    output logic [3:0]               ram_address,
    output logic                     ram_CE_bar,
    output logic                     ram_run_or_prog,
    output logic                     ram_read_or_write,
    output logic [7:0]               ram_programmer_data,
    input  logic [7:0]               ram_memory_value,
    output logic                     busy,
    output logic                     done,
    output logic                     error,
    output logic [7:0]               checksum
);

    // Parameters below 1 would collapse a phase to zero cycles; clamp them so the
    // strobe timing is always at least one cycle per phase.
    localparam int SETUP_N = (SETUP_CYCLES < 1) ? 1 : SETUP_CYCLES;
    localparam int WRITE_N = (WRITE_PULSE_CYCLES < 1) ? 1 : WRITE_PULSE_CYCLES;
    localparam logic [7:0] SETUP_LAST = 8'(SETUP_N - 1);
    localparam logic [7:0] WRITE_LAST = 8'(WRITE_N - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACCEPT,
        S_SETUP,
        S_WRITE,
        S_HOLD,
        S_VERIFY,
        S_DONE,
        S_ERROR
    } state_t;

    state_t     state, state_nxt;
    logic [3:0] ptr, ptr_nxt;
    logic [7:0] data_q, data_nxt;
    logic [7:0] sum, sum_nxt;
    logic [7:0] vsum, vsum_nxt;
    logic [7:0] cnt, cnt_nxt;
    logic       done_q, done_nxt;
    logic       error_q, error_nxt;
    logic [7:0] checksum_q, checksum_nxt;
    logic [7:0] vsum_add;

    // Running read-back sum including the location addressed this cycle; the
    // final compare uses it so the last byte counts without an extra cycle.
    assign vsum_add = vsum + ram_memory_value;

    always_ff @(posedge CLK) begin
        if (CLR) begin
            state      <= S_IDLE;
            ptr        <= 4'd0;
            data_q     <= 8'd0;
            sum        <= 8'd0;
            vsum       <= 8'd0;
            cnt        <= 8'd0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            checksum_q <= 8'd0;
        end else begin
            state      <= state_nxt;
            ptr        <= ptr_nxt;
            data_q     <= data_nxt;
            sum        <= sum_nxt;
            vsum       <= vsum_nxt;
            cnt        <= cnt_nxt;
            done_q     <= done_nxt;
            error_q    <= error_nxt;
            checksum_q <= checksum_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        ptr_nxt      = ptr;
        data_nxt     = data_q;
        sum_nxt      = sum;
        vsum_nxt     = vsum;
        cnt_nxt      = cnt;
        done_nxt     = done_q;
        error_nxt    = error_q;
        checksum_nxt = checksum_q;

        // Default is CPU pass-through in run mode with the write strobe idle.
        ram_address         = cpu_address;
        ram_CE_bar          = cpu_CE_bar;
        ram_run_or_prog     = 1'b1;
        ram_read_or_write   = 1'b1;
        ram_programmer_data = data_q;
        byte_if.byte_ready  = 1'b0;
        busy                = 1'b1;

        case (state)
            S_IDLE, S_DONE, S_ERROR: begin
                busy = 1'b0;
                if (start) begin
                    state_nxt = S_ACCEPT;
                    done_nxt  = 1'b0;
                    error_nxt = 1'b0;
                    ptr_nxt   = 4'd0;
                    sum_nxt   = 8'd0;
                    vsum_nxt  = 8'd0;
                end
            end

            S_ACCEPT: begin
                ram_run_or_prog    = 1'b0;
                ram_CE_bar         = 1'b1;
                ram_address        = ptr;
                byte_if.byte_ready = 1'b1;
                if (byte_if.byte_valid) begin
                    data_nxt  = byte_if.byte_data;
                    sum_nxt   = sum + byte_if.byte_data;
                    cnt_nxt   = 8'd0;
                    state_nxt = S_SETUP;
                end
            end

            S_SETUP: begin
                ram_run_or_prog = 1'b0;
                ram_CE_bar      = 1'b1;
                ram_address     = ptr;
                if (cnt == SETUP_LAST) begin
                    cnt_nxt   = 8'd0;
                    state_nxt = S_WRITE;
                end else begin
                    cnt_nxt = cnt + 8'd1;
                end
            end

            S_WRITE: begin
                ram_run_or_prog   = 1'b0;
                ram_CE_bar        = 1'b1;
                ram_address       = ptr;
                ram_read_or_write = 1'b0;
                if (cnt == WRITE_LAST) begin
                    cnt_nxt   = 8'd0;
                    state_nxt = S_HOLD;
                end else begin
                    cnt_nxt = cnt + 8'd1;
                end
            end

            // The strobe has already risen; ptr only moves on the edge leaving
            // HOLD so address/data stay put across the rising edge.
            S_HOLD: begin
                ram_run_or_prog = 1'b0;
                ram_CE_bar      = 1'b1;
                ram_address     = ptr;
                if (ptr == 4'hF) begin
                    ptr_nxt = 4'd0;
                    if (VERIFY_EN) begin
                        state_nxt = S_VERIFY;
                    end else begin
                        state_nxt    = S_DONE;
                        done_nxt     = 1'b1;
                        checksum_nxt = sum;
                    end
                end else begin
                    ptr_nxt   = ptr + 4'd1;
                    state_nxt = S_ACCEPT;
                end
            end

            S_VERIFY: begin
                ram_CE_bar  = 1'b0;
                ram_address = ptr;
                vsum_nxt    = vsum_add;
                ptr_nxt     = ptr + 4'd1;
                if (ptr == 4'hF) begin
                    checksum_nxt = sum;
                    if (vsum_add == sum) begin
                        state_nxt = S_DONE;
                        done_nxt  = 1'b1;
                    end else begin
                        state_nxt = S_ERROR;
                        error_nxt = 1'b1;
                    end
                end
            end

            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    assign done     = done_q;
    assign error    = error_q;
    assign checksum = checksum_q;

endmodule
